// File: rtl/adder_result_accum.sv
// rtl/adder_result_accum.sv - frame accumulator for the four 2-bit adder results (optional ACC_SAT_EN saturation)

module adder_result_accum #(
    parameter int ACC_W       = 8,
    parameter int NUM_SAMPLES = 16,
    localparam int CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_z,
    input  logic [1:0]       in_x,
    input  logic [1:0]       in_y,
    input  logic [1:0]       in_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [3:0]       beat_sum;
    logic [ACC_W:0]   acc_base;
    logic [ACC_W:0]   sum_full;
    logic [ACC_W-1:0] acc_next;
    logic             carry;
    logic             accept;
    logic             last_beat;

    assign beat_sum = {2'b00, in_z} + {2'b00, in_x} + {2'b00, in_y} + {2'b00, in_v};

    // A new frame starts from zero regardless of what acc_out held.
    assign acc_base = (state == S_IDLE) ? '0 : {1'b0, acc_out};
    assign sum_full = acc_base + {{(ACC_W - 3){1'b0}}, beat_sum};
    assign carry    = sum_full[ACC_W];

`ifdef ACC_SAT_EN
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign acc_next = sum_full[ACC_W-1:0];
`endif

    assign in_ready  = ena & (state != S_DONE) & ~clear & ~reset;
    assign accept    = in_valid & in_ready;
    assign last_beat = (beat_cnt == CNT_W'(NUM_SAMPLES - 1));
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= S_IDLE;
            acc_out  <= '0;
            beat_cnt <= '0;
            overflow <= 1'b0;
        end else if (ena) begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc_out  <= acc_next;
                        beat_cnt <= beat_cnt + 1'b1;
                        overflow <= overflow | carry;
                        state    <= last_beat ? S_DONE : S_ACCUM;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state    <= S_IDLE;
                        acc_out  <= '0;
                        beat_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_result_accum.sv
// tb/tb_adder_result_accum.sv - directed vector bench for adder_result_accum (ACC_W 8 and 5, NUM_SAMPLES 4)

module tb_adder_result_accum;

    logic       clk = 1'b0;
    logic       reset, ena, clear, in_valid, out_ready;
    logic [1:0] in_z, in_x, in_y, in_v;
    logic       in_ready, out_valid, overflow;
    logic [7:0] acc_out;
    logic [2:0] beat_cnt;
    logic       in_ready5, out_valid5, overflow5;
    logic [4:0] acc_out5;
    logic [2:0] beat_cnt5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_result_accum #(.ACC_W(8), .NUM_SAMPLES(4)) dut (
        .clk(clk), .reset(reset), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z(in_z), .in_x(in_x), .in_y(in_y), .in_v(in_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .beat_cnt(beat_cnt), .overflow(overflow)
    );

    adder_result_accum #(.ACC_W(5), .NUM_SAMPLES(4)) dut5 (
        .clk(clk), .reset(reset), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready5),
        .in_z(in_z), .in_x(in_x), .in_y(in_y), .in_v(in_v),
        .out_valid(out_valid5), .out_ready(out_ready),
        .acc_out(acc_out5), .beat_cnt(beat_cnt5), .overflow(overflow5)
    );

    typedef struct {
        string      name;
        logic       rst, clr, en, iv, ordy;
        logic [1:0] z, x, y, v;
        logic       e_ready;
        logic [7:0] e_acc;
        logic [2:0] e_cnt;
        logic       e_ov, e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic rst, logic clr, logic en, logic iv, logic ordy,
                                logic [1:0] z, logic [1:0] x, logic [1:0] y, logic [1:0] v,
                                logic e_ready, logic [7:0] e_acc, logic [2:0] e_cnt,
                                logic e_ov, logic e_ovf);
        vec_t t;
        t.name = name; t.rst = rst; t.clr = clr; t.en = en; t.iv = iv; t.ordy = ordy;
        t.z = z; t.x = x; t.y = y; t.v = v;
        t.e_ready = e_ready; t.e_acc = e_acc; t.e_cnt = e_cnt; t.e_ov = e_ov; t.e_ovf = e_ovf;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        reset = t.rst; clear = t.clr; ena = t.en; in_valid = t.iv; out_ready = t.ordy;
        in_z = t.z; in_x = t.x; in_y = t.y; in_v = t.v;
        #1;
        check({t.name, ".in_ready"}, 32'(in_ready), 32'(t.e_ready));
        @(posedge clk);
        #1;
        check({t.name, ".acc_out"},   32'(acc_out),   32'(t.e_acc));
        check({t.name, ".beat_cnt"},  32'(beat_cnt),  32'(t.e_cnt));
        check({t.name, ".out_valid"}, 32'(out_valid), 32'(t.e_ov));
        check({t.name, ".overflow"},  32'(overflow),  32'(t.e_ovf));
    endtask

    localparam logic [4:0] EXP_ACC5 =
`ifdef ACC_SAT_EN
        5'd31;
`else
        5'd16;
`endif

    initial begin
        reset = 1'b1; clear = 1'b0; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_z = '0; in_x = '0; in_y = '0; in_v = '0;

        // Reset, then basic frame of four sum-12 beats; DONE on the cycle after the 4th accept.
        vecs.push_back(mk("rst",   1,0,1,1,0, 3,3,3,3, 0,  0,0,0,0));
        vecs.push_back(mk("b1",    0,0,1,1,0, 3,3,3,3, 1, 12,1,0,0));
        vecs.push_back(mk("b2",    0,0,1,1,0, 3,3,3,3, 1, 24,2,0,0));
        vecs.push_back(mk("b3",    0,0,1,1,0, 3,3,3,3, 1, 36,3,0,0));
        vecs.push_back(mk("b4",    0,0,1,1,0, 3,3,3,3, 1, 48,4,1,0));
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();

        check("ovf5.acc_out",   32'(acc_out5),   32'(EXP_ACC5));
        check("ovf5.overflow",  32'(overflow5),  32'd1);
        check("ovf5.out_valid", 32'(out_valid5), 32'd1);

        // Backpressure: DONE held, input ignored.
        for (int i = 0; i < 5; i++)
            apply(mk("bp", 0,0,1,1,0, 3,3,3,3, 0, 48,4,1,0));
        check("bp5.acc_out", 32'(acc_out5), 32'(EXP_ACC5));
        apply(mk("rel", 0,0,1,1,1, 3,3,3,3, 0, 0,0,0,0));
        check("rel5.overflow", 32'(overflow5), 32'd0);

        // Clear mid-frame drops the clear-cycle beat; then ena gating with gaps.
        vecs.push_back(mk("c1",    0,0,1,1,0, 2,2,1,0, 1,  5,1,0,0));
        vecs.push_back(mk("c2",    0,0,1,1,0, 2,2,1,0, 1, 10,2,0,0));
        vecs.push_back(mk("clr",   0,1,1,1,0, 2,2,1,0, 0,  0,0,0,0));
        vecs.push_back(mk("g1",    0,0,1,1,0, 1,1,1,1, 1,  4,1,0,0));
        vecs.push_back(mk("en0a",  0,0,0,1,0, 1,1,1,1, 0,  4,1,0,0));
        vecs.push_back(mk("en0b",  0,0,0,1,0, 1,1,1,1, 0,  4,1,0,0));
        vecs.push_back(mk("en0c",  0,0,0,1,0, 1,1,1,1, 0,  4,1,0,0));
        vecs.push_back(mk("gap1",  0,0,1,0,0, 1,1,1,1, 1,  4,1,0,0));
        vecs.push_back(mk("g2",    0,0,1,1,0, 1,1,1,1, 1,  8,2,0,0));
        vecs.push_back(mk("gap2",  0,0,1,0,0, 1,1,1,1, 1,  8,2,0,0));
        vecs.push_back(mk("g3",    0,0,1,1,0, 1,1,1,1, 1, 12,3,0,0));
        vecs.push_back(mk("gap3",  0,0,1,0,0, 1,1,1,1, 1, 12,3,0,0));
        vecs.push_back(mk("g4",    0,0,1,1,0, 1,1,1,1, 1, 16,4,1,0));
        // Handshake with ena low does not complete.
        vecs.push_back(mk("hs_en0",0,0,0,1,1, 1,1,1,1, 0, 16,4,1,0));
        // Reset while DONE, then a fresh frame starts.
        vecs.push_back(mk("rstd",  1,0,1,1,1, 1,1,1,1, 0,  0,0,0,0));
        vecs.push_back(mk("nf1",   0,0,1,1,0, 0,1,2,3, 1,  6,1,0,0));
        // Clear in DONE beats out_ready.
        vecs.push_back(mk("nf2",   0,0,1,1,0, 3,3,3,3, 1, 18,2,0,0));
        vecs.push_back(mk("nf3",   0,0,1,1,0, 3,3,3,3, 1, 30,3,0,0));
        vecs.push_back(mk("nf4",   0,0,1,1,0, 3,3,3,3, 1, 42,4,1,0));
        vecs.push_back(mk("clrd",  0,1,1,1,1, 3,3,3,3, 0,  0,0,0,0));
        vecs.push_back(mk("post",  0,0,1,1,0, 3,0,0,0, 1,  3,1,0,0));
        foreach (vecs[i]) apply(vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
